resp_encoder: RTL and testbench
===============================

Name: resp_encoder

Overview:
- Transmit-side framer for the host serial link, the counterpart of the command decoder.
- Collects payload bytes from one internal source at a time and buffers a whole payload.
- Emits a frame to the UART transmitter: `PREFIX, `ADDR_HOST, SRC, LEN, DATA[LEN], CRC.
- CRC = 8-bit modulo-256 sum of the DATA bytes only, so host and board use identical framing and checksum.

Parameters:
- MAX_LEN, 255: payload bytes per frame; a frame closes automatically at this count; legal range 1..255.
- FLUSH_CYC, 50000: idle clocks after the last accepted byte before a partial frame is closed (1 ms at 50 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- data_in  in  8  payload byte.
- data_valid  in  1  data_in valid; accepted when data_valid & data_ready.
- data_last  in  1  qualifies the accepted byte as the final byte of the payload.
- src_id  in  8  source tag; sampled with the first byte of each frame.
- data_ready  out  1  block accepts payload bytes; high only in COLLECT.
- tx_data  out  8  byte to the UART transmitter, registered.
- tx_valid  out  1  tx_data valid, registered.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- busy  out  1  high from frame close until CRC byte accepted.

Behaviour:
- Reset (async, nrst=0), effective immediately and mid-frame:
  - state=COLLECT; tx_valid=0; tx_data=0; busy=0.
  - cnt=0; crc=0; src latch=0.
  - FIFO cleared; partial frame discarded.
  - data_ready=1 once nrst=1.
- COLLECT:
  - Accepted byte: written to FIFO; cnt+1; crc+=data_in (wraps mod 256).
  - First accepted byte (cnt=0) also latches src_id. Later src_id changes are ignored until the next frame.
  - Frame closes on an accepted byte when data_last=1 or new cnt==MAX_LEN. Next cycle: state=SEND_PREFIX, data_ready=0, busy=1.
  - A frame never has LEN=0. Idle with cnt=0 never closes.
- Send states advance only on tx_valid & tx_ready:
  - Sequence: SEND_PREFIX -> SEND_ADDR -> SEND_SRC -> SEND_LEN -> SEND_DATA -> SEND_CRC -> COLLECT.
  - tx_valid is high in every send state. The first tx_valid comes 1 clock after the closing byte.
  - tx_data and tx_valid hold stable while tx_ready=0.
  - Back-to-back bytes are possible: 1 byte per clock when tx_ready stays high.
- SEND_DATA:
  - The FIFO is read on each accepted byte; a second counter runs to LEN.
  - Exit to SEND_CRC after byte LEN is accepted.
- SEND_CRC: on acceptance, clear cnt and crc and set busy=0. data_ready=1 from the following cycle.
- Simultaneous events:
  - data_valid during the send states is not accepted; data_ready=0 and the source must hold.
  - A byte with data_last=1 that also reaches MAX_LEN closes exactly one frame.
  - A MAX_LEN closure without data_last: the following bytes start a new frame with a freshly sampled src_id.

Optional Feature:
- Macro: RESP_ENC_AUTO_FLUSH_EN.
- Defined:
  - A 32-bit idle counter runs in COLLECT while cnt>0 and clears on every accepted byte.
  - On reaching FLUSH_CYC-1, the partial frame closes exactly as if data_last had been given. LEN=cnt and CRC cover the bytes received.
  - The counter clears in all other states.
- Undefined: no counter exists; frames close only on data_last or MAX_LEN; a partial payload waits indefinitely.

Decomposition:
- defines.v (shared):
  - `PREFIX and `ADDR_AST (existing).
  - New `ADDR_HOST.
  - State encodings as localparams inside the module.
- One sub-module, resp_fifo:
  - 256x8 synchronous FIFO, show-ahead.
  - Ports: clk, nrst (aclr), sclr, wrreq, rdreq, data, q, empty, full.
  - sclr is unused in normal flow and driven only by reset logic.

Test Plan:
- Basic frame: bytes 0x11, 0x22, 0x33 with src_id=0x02 and last on 0x33, tx_ready=1 -> tx sequence `PREFIX, `ADDR_HOST, 0x02, 0x03, 0x11, 0x22, 0x33, 0x66 on 8 consecutive clocks; busy high throughout.
- CRC wrap: payload 0xF0, 0x20 -> CRC byte 0x10.
- Backpressure: tx_ready toggling 1/0 every clock during the basic frame -> same 8 bytes, each held while tx_ready=0; data_ready stays 0 until CRC is accepted.
- MAX_LEN split (MAX_LEN=4): 6 bytes 0x01..0x06, last on 0x06 -> frame LEN=4, CRC=0x0A, then frame LEN=2, CRC=0x0B.
- Auto flush (macro defined, FLUSH_CYC=100): 2 bytes, no last, then idle -> frame LEN=2 starts 101 clocks after the second byte. Macro undefined: no output.
- Reset mid-frame: nrst low during SEND_DATA -> tx_valid=0 immediately; after release, a new 1-byte frame is emitted with correct LEN and CRC and no stale data.

Source files
------------

// File: rtl/resp_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resp_encoder_pkg
// Description : Shared framing constants and FSM state encoding for the
//               host-link response encoder.
//               C_PREFIX    - start-of-frame marker byte
//               C_ADDR_AST  - address byte of the board-side node
//               C_ADDR_HOST - address byte of the host (destination here)
// Revision    : 1.0 - initial release
// ============================================================================
package resp_encoder_pkg;

  localparam logic [7:0] C_PREFIX    = 8'hA5;
  localparam logic [7:0] C_ADDR_AST  = 8'h01;
  localparam logic [7:0] C_ADDR_HOST = 8'h80;

  typedef enum logic [2:0] {
    ST_COLLECT     = 3'd0,
    ST_SEND_PREFIX = 3'd1,
    ST_SEND_ADDR   = 3'd2,
    ST_SEND_SRC    = 3'd3,
    ST_SEND_LEN    = 3'd4,
    ST_SEND_DATA   = 3'd5,
    ST_SEND_CRC    = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/resp_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : resp_encoder_if
// Description : Payload-in and UART-byte-out signals of the response encoder.
//   data_in/data_valid/data_last/src_id : payload source -> encoder
//   data_ready                          : encoder -> payload source
//   tx_data/tx_valid                    : encoder -> UART transmitter
//   tx_ready                            : UART transmitter -> encoder
//   busy                                : frame in transmission
//   master : environment side (source + transmitter), slave : the encoder
// Revision    : 1.0 - initial release
// ============================================================================
interface resp_encoder_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic [7:0] src_id;
  logic       data_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  modport master (
    output data_in, data_valid, data_last, src_id, tx_ready,
    input  data_ready, tx_data, tx_valid, busy
  );

  modport slave (
    input  data_in, data_valid, data_last, src_id, tx_ready,
    output data_ready, tx_data, tx_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/resp_encoder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_fifo
// Description : Synchronous show-ahead FIFO (q shows the head entry while
//               not empty; rdreq pops it). Default 256 x 8.
//   clk, nrst (async clear, active-low), sclr (sync clear)
//   wrreq/data : push,  rdreq/q : pop,  empty/full : status
// Revision    : 1.0 - initial release
// ============================================================================
module resp_fifo #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic             rdreq,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full
);

  localparam int C_DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [C_DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign w_wr_en = wrreq & ~full;
  assign w_rd_en = rdreq & ~empty;

  // Storage is not reset; only the pointers define valid content.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{DEPTH_LOG2{1'b0}}, w_wr_en}
                         - {{DEPTH_LOG2{1'b0}}, w_rd_en};
    end
  end

  assign q     = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = count_q[DEPTH_LOG2];

endmodule
`default_nettype wire

// File: rtl/resp_encoder.sv
`default_nettype none
// ============================================================================
// Module      : resp_encoder
// Description : Transmit-side framer for the host serial link. Buffers one
//               payload, then emits PREFIX, ADDR_HOST, SRC, LEN, DATA[LEN],
//               CRC (mod-256 sum of DATA) to the UART transmitter.
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : resp_encoder_if.slave (payload in, tx bytes out, busy)
//   MAX_LEN   : payload bytes that force a frame close (1..255)
//   FLUSH_CYC : idle clocks before a partial frame is flushed
// Optional    : RESP_ENC_AUTO_FLUSH_EN enables the idle auto-flush timer.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_encoder
  import resp_encoder_pkg::*;
#(
  parameter int MAX_LEN   = 255,
  parameter int FLUSH_CYC = 50000
) (
  input  logic          clk,
  input  logic          nrst,
  resp_encoder_if.slave bus
);

  localparam logic [7:0] C_MAX_LEN = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] src_q, src_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       busy_q, busy_d;

  logic       w_ready;
  logic       w_accept;
  logic       w_tx_fire;
  logic       w_flush;
  logic       w_fifo_rd;
  logic [7:0] w_fifo_q;
  logic       w_fifo_empty;
  logic       w_fifo_full;

  assign w_ready   = (state_q == ST_COLLECT) & ~w_fifo_full;
  assign w_accept  = bus.data_valid & w_ready;
  assign w_tx_fire = tx_valid_q & bus.tx_ready;

`ifdef RESP_ENC_AUTO_FLUSH_EN
  logic [31:0] idle_q, idle_d;

  // Counts idle clocks only while a partial payload is pending.
  always_comb begin
    idle_d = '0;
    if ((state_q == ST_COLLECT) && (cnt_q != 8'd0) && !w_accept)
      idle_d = idle_q + 32'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign w_flush = (state_q == ST_COLLECT) && (cnt_q != 8'd0) &&
                   (idle_q == 32'(FLUSH_CYC - 1));
`else
  // The flush timeout only matters when the auto-flush timer is built in.
  logic w_unused_flush_cfg;
  assign w_unused_flush_cfg = ^32'(FLUSH_CYC);
  assign w_flush = 1'b0;
`endif

  resp_fifo #(.DEPTH_LOG2(8), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .sclr  (1'b0),
    .wrreq (w_accept),
    .rdreq (w_fifo_rd & ~w_fifo_empty),
    .data  (bus.data_in),
    .q     (w_fifo_q),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  // tx_data/tx_valid are loaded with the byte belonging to the state being
  // entered, so the output register always matches the current send state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    src_d      = src_q;
    pos_d      = pos_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    w_fifo_rd  = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (w_accept) begin
          cnt_d = cnt_q + 8'd1;
          crc_d = crc_q + bus.data_in;
          if (cnt_q == 8'd0) src_d = bus.src_id;
        end
        if ((w_accept && (bus.data_last || (cnt_q + 8'd1 == C_MAX_LEN))) ||
            (!w_accept && w_flush)) begin
          state_d    = ST_SEND_PREFIX;
          tx_data_d  = C_PREFIX;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_SEND_PREFIX: if (w_tx_fire) begin
        state_d   = ST_SEND_ADDR;
        tx_data_d = C_ADDR_HOST;
      end
      ST_SEND_ADDR: if (w_tx_fire) begin
        state_d   = ST_SEND_SRC;
        tx_data_d = src_q;
      end
      ST_SEND_SRC: if (w_tx_fire) begin
        state_d   = ST_SEND_LEN;
        tx_data_d = cnt_q;
      end
      ST_SEND_LEN: if (w_tx_fire) begin
        // Show-ahead head is the first payload byte; pop it as it is loaded.
        state_d   = ST_SEND_DATA;
        tx_data_d = w_fifo_q;
        w_fifo_rd = 1'b1;
        pos_d     = 8'd1;
      end
      ST_SEND_DATA: if (w_tx_fire) begin
        // pos_q = payload bytes already loaded into the output register.
        if (pos_q == cnt_q) begin
          state_d   = ST_SEND_CRC;
          tx_data_d = crc_q;
        end else begin
          tx_data_d = w_fifo_q;
          w_fifo_rd = 1'b1;
          pos_d     = pos_q + 8'd1;
        end
      end
      ST_SEND_CRC: if (w_tx_fire) begin
        state_d    = ST_COLLECT;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        cnt_d      = 8'd0;
        crc_d      = 8'd0;
        pos_d      = 8'd0;
      end
      default: begin
        state_d    = ST_COLLECT;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_COLLECT;
      cnt_q      <= 8'd0;
      crc_q      <= 8'd0;
      src_q      <= 8'd0;
      pos_q      <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      src_q      <= src_d;
      pos_q      <= pos_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.data_ready = w_ready;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_resp_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_encoder
// Description : Directed self-checking bench for resp_encoder (MAX_LEN=4,
//               FLUSH_CYC=100). Frame constants: PREFIX=A5, ADDR_HOST=80.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_encoder;

  localparam int MAX_LEN   = 4;
  localparam int FLUSH_CYC = 100;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  resp_encoder_if bus ();

  resp_encoder #(.MAX_LEN(MAX_LEN), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] cap [16];
  int cap_n, cap_first, cap_last, hold_err, dr_err, busy_err;

  // Drive one payload byte; waits (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] d, input logic [7:0] src, input bit last);
    bit done = 1'b0;
    @(negedge clk);
    bus.data_in    = d;
    bus.src_id     = src;
    bus.data_last  = last;
    bus.data_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.data_ready === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    bus.data_valid = 1'b0;
    bus.data_last  = 1'b0;
    n_total++;
    if (!done) $display("FAIL send_byte_accept: byte %02h got not-accepted want accepted", d);
    else n_pass++;
  endtask

  // Monitor tx side for up to 'bound' clocks, recording accepted bytes.
  task automatic capture(input int n_exp, input int bound, input bit bp);
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    for (int i = 0; i < 16; i++) cap[i] = 8'hxx;
    cap_n = 0; cap_first = -1; cap_last = -1;
    hold_err = 0; dr_err = 0; busy_err = 0;
    for (int c = 0; c < bound && cap_n < n_exp; c++) begin
      @(negedge clk);
      bus.tx_ready = bp ? (c % 2 == 0) : 1'b1;
      if (bus.tx_valid === 1'b1) begin
        if (bus.busy !== 1'b1) busy_err++;
        if (bus.data_ready !== 1'b0) dr_err++;
        if (prev_stall && bus.tx_data !== prev_data) hold_err++;
        prev_stall = !bus.tx_ready;
        prev_data  = bus.tx_data;
        if (bus.tx_ready) begin
          if (cap_n < 16) cap[cap_n] = bus.tx_data;
          if (cap_first < 0) cap_first = c;
          cap_last = c;
          cap_n++;
        end
      end else begin
        if (prev_stall) hold_err++;
        prev_stall = 1'b0;
      end
      @(posedge clk);
    end
    #1 bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %02h want 00", bus.tx_data); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    nrst = 1'b1;
    @(negedge clk);
    n_total++; if (bus.data_ready !== 1'b1) $display("FAIL reset_data_ready: got %b want 1", bus.data_ready); else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] exp [8] = '{8'hA5, 8'h80, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_byte(8'h11, 8'h02, 1'b0);
    send_byte(8'h22, 8'h02, 1'b0);
    send_byte(8'h33, 8'h02, 1'b1);
    capture(8, 40, 1'b0);
    n_total++; if (cap_n !== 8) $display("FAIL basic_count: got %0d want 8", cap_n); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (cap[i] !== exp[i]) $display("FAIL basic_byte%0d: got %02h want %02h", i, cap[i], exp[i]);
      else n_pass++;
    end
    n_total++; if (cap_first !== 0 || cap_last !== 7) $display("FAIL basic_timing: got first %0d last %0d want 0 7", cap_first, cap_last); else n_pass++;
    n_total++; if (busy_err !== 0) $display("FAIL basic_busy: got %0d low cycles want 0", busy_err); else n_pass++;
    n_total++; if (dr_err !== 0) $display("FAIL basic_data_ready: got %0d high cycles want 0", dr_err); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.data_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL basic_after: got ready %b busy %b want 1 0", bus.data_ready, bus.busy); else n_pass++;
  endtask

  task automatic test_crc_wrap();
    logic [7:0] exp [7] = '{8'hA5, 8'h80, 8'h07, 8'h02, 8'hF0, 8'h20, 8'h10};
    send_byte(8'hF0, 8'h07, 1'b0);
    send_byte(8'h20, 8'h07, 1'b1);
    capture(7, 40, 1'b0);
    n_total++; if (cap_n !== 7) $display("FAIL crc_wrap_count: got %0d want 7", cap_n); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (cap[i] !== exp[i]) $display("FAIL crc_wrap_byte%0d: got %02h want %02h", i, cap[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [8] = '{8'hA5, 8'h80, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_byte(8'h11, 8'h02, 1'b0);
    send_byte(8'h22, 8'h02, 1'b0);
    send_byte(8'h33, 8'h02, 1'b1);
    capture(8, 60, 1'b1);
    n_total++; if (cap_n !== 8) $display("FAIL bp_count: got %0d want 8", cap_n); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (cap[i] !== exp[i]) $display("FAIL bp_byte%0d: got %02h want %02h", i, cap[i], exp[i]);
      else n_pass++;
    end
    n_total++; if (hold_err !== 0) $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_err); else n_pass++;
    n_total++; if (dr_err !== 0) $display("FAIL bp_data_ready: got %0d high cycles want 0", dr_err); else n_pass++;
    n_total++; if (cap_first !== 0 || cap_last !== 14) $display("FAIL bp_timing: got first %0d last %0d want 0 14", cap_first, cap_last); else n_pass++;
  endtask

  task automatic test_max_split();
    logic [7:0] exp1 [9] = '{8'hA5, 8'h80, 8'h05, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    logic [7:0] exp2 [7] = '{8'hA5, 8'h80, 8'h09, 8'h02, 8'h05, 8'h06, 8'h0B};
    send_byte(8'h01, 8'h05, 1'b0);
    send_byte(8'h02, 8'h0C, 1'b0);
    send_byte(8'h03, 8'h0C, 1'b0);
    send_byte(8'h04, 8'h0C, 1'b0);
    // Byte 5 is offered while frame 1 is still being sent and must wait.
    fork
      begin
        send_byte(8'h05, 8'h09, 1'b0);
        send_byte(8'h06, 8'h09, 1'b1);
      end
      capture(9, 60, 1'b0);
    join
    n_total++; if (cap_n !== 9) $display("FAIL split1_count: got %0d want 9", cap_n); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      n_total++;
      if (cap[i] !== exp1[i]) $display("FAIL split1_byte%0d: got %02h want %02h", i, cap[i], exp1[i]);
      else n_pass++;
    end
    capture(7, 40, 1'b0);
    n_total++; if (cap_n !== 7) $display("FAIL split2_count: got %0d want 7", cap_n); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (cap[i] !== exp2[i]) $display("FAIL split2_byte%0d: got %02h want %02h", i, cap[i], exp2[i]);
      else n_pass++;
    end
  endtask

  task automatic test_last_at_max();
    logic [7:0] exp [9] = '{8'hA5, 8'h80, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    int extra = 0;
    send_byte(8'h01, 8'h03, 1'b0);
    send_byte(8'h02, 8'h03, 1'b0);
    send_byte(8'h03, 8'h03, 1'b0);
    send_byte(8'h04, 8'h03, 1'b1);
    capture(9, 40, 1'b0);
    n_total++; if (cap_n !== 9) $display("FAIL lastmax_count: got %0d want 9", cap_n); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      n_total++;
      if (cap[i] !== exp[i]) $display("FAIL lastmax_byte%0d: got %02h want %02h", i, cap[i], exp[i]);
      else n_pass++;
    end
    bus.tx_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    bus.tx_ready = 1'b0;
    n_total++; if (extra !== 0) $display("FAIL lastmax_single_frame: got %0d active cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_auto_flush();
`ifdef RESP_ENC_AUTO_FLUSH_EN
    logic [7:0] exp [7] = '{8'hA5, 8'h80, 8'h0E, 8'h02, 8'h21, 8'h43, 8'h64};
    send_byte(8'h21, 8'h0E, 1'b0);
    send_byte(8'h43, 8'h0E, 1'b0);
    capture(7, 250, 1'b0);
    n_total++; if (cap_n !== 7) $display("FAIL flush_count: got %0d want 7", cap_n); else n_pass++;
    n_total++; if (cap_first !== FLUSH_CYC) $display("FAIL flush_delay: got %0d want %0d", cap_first, FLUSH_CYC); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (cap[i] !== exp[i]) $display("FAIL flush_byte%0d: got %02h want %02h", i, cap[i], exp[i]);
      else n_pass++;
    end
`else
    logic [7:0] exp [8] = '{8'hA5, 8'h80, 8'h0E, 8'h03, 8'h21, 8'h43, 8'h10, 8'h74};
    int act = 0;
    send_byte(8'h21, 8'h0E, 1'b0);
    send_byte(8'h43, 8'h0E, 1'b0);
    bus.tx_ready = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0) act++;
    end
    bus.tx_ready = 1'b0;
    n_total++; if (act !== 0) $display("FAIL noflush_idle: got %0d tx_valid cycles want 0", act); else n_pass++;
    send_byte(8'h10, 8'h55, 1'b1);
    capture(8, 40, 1'b0);
    n_total++; if (cap_n !== 8) $display("FAIL noflush_count: got %0d want 8", cap_n); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (cap[i] !== exp[i]) $display("FAIL noflush_byte%0d: got %02h want %02h", i, cap[i], exp[i]);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp [6] = '{8'hA5, 8'h80, 8'h0B, 8'h01, 8'h3C, 8'h3C};
    send_byte(8'hAA, 8'h06, 1'b0);
    send_byte(8'hBB, 8'h06, 1'b0);
    send_byte(8'hCC, 8'h06, 1'b0);
    send_byte(8'hDD, 8'h06, 1'b0);
    capture(5, 20, 1'b0);
    @(negedge clk);
    n_total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hBB) $display("FAIL midframe_pre: got valid %b data %02h want 1 BB", bus.tx_valid, bus.tx_data); else n_pass++;
    nrst = 1'b0;
    #1;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL midframe_tx_valid: got %b want 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.tx_data !== 8'h00 || bus.busy !== 1'b0) $display("FAIL midframe_regs: got data %02h busy %b want 00 0", bus.tx_data, bus.busy); else n_pass++;
    @(negedge clk);
    nrst = 1'b1;
    send_byte(8'h3C, 8'h0B, 1'b1);
    capture(6, 30, 1'b0);
    n_total++; if (cap_n !== 6) $display("FAIL midframe_count: got %0d want 6", cap_n); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (cap[i] !== exp[i]) $display("FAIL midframe_byte%0d: got %02h want %02h", i, cap[i], exp[i]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++; if (bus.tx_valid !== 1'b0 || bus.data_ready !== 1'b1) $display("FAIL midframe_idle: got valid %b ready %b want 0 1", bus.tx_valid, bus.data_ready); else n_pass++;
  endtask

  initial begin
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    bus.data_last  = 1'b0;
    bus.src_id     = 8'h00;
    bus.tx_ready   = 1'b0;
    test_reset();
    test_basic();
    test_crc_wrap();
    test_backpressure();
    test_max_split();
    test_last_at_max();
    test_auto_flush();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
